// File: rtl/hyperspace_out_framer.sv
// hyperspace_out_framer: FIFO-buffered pad-side output stage that regenerates and checks FRAME_LEN framing.
// Optional build define HYPERSPACE_OUT_BITREV_EN bit-reverses m_data for reversed pad bus wiring.
module hyperspace_out_framer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 1536
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                frame_cnt,
  output logic                       frame_err,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

`ifdef HYPERSPACE_OUT_BITREV_EN
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction
`endif

  logic [DATA_W:0]   mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [CW-1:0]     wcnt_r;
  logic [15:0]       frame_cnt_r;
  logic              frame_err_r;

  logic              push_s;
  logic              pop_s;
  logic              head_last_s;
  logic              at_end_s;
  logic              mismatch_s;
  logic              m_last_s;
  logic [DATA_W-1:0] head_data_s;
  logic [LW-1:0]     level_nxt_s;
  logic [CW-1:0]     wcnt_nxt_s;
  logic [15:0]       frame_cnt_nxt_s;
  logic              frame_err_nxt_s;

  // Handshakes come from registered occupancy only, so m_ready never reaches s_ready.
  assign s_ready     = (level_r != FULL_LVL);
  assign m_valid     = (level_r != {LW{1'b0}});
  assign push_s      = s_valid & s_ready;
  assign pop_s       = m_valid & m_ready;
  assign head_last_s = mem_r[rd_ptr_r][DATA_W];
  assign head_data_s = mem_r[rd_ptr_r][DATA_W-1:0];
  assign at_end_s    = (wcnt_r == LAST_IDX);
  assign m_last_s    = m_valid & (head_last_s | at_end_s);
  assign mismatch_s  = pop_s & (head_last_s != at_end_s);

  assign m_last      = m_last_s;
  assign level       = level_r;
  assign frame_cnt   = frame_cnt_r;
  assign frame_err   = frame_err_r;

`ifdef HYPERSPACE_OUT_BITREV_EN
  assign m_data = bit_reverse(head_data_s);
`else
  assign m_data = head_data_s;
`endif

  // FIFO storage and pointers; storage is cleared so m_data reads zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(DATA_W+1){1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {s_last, s_data};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Next-state for occupancy, in-frame word counter, frame counter and sticky error.
  always_comb begin
    level_nxt_s     = level_r;
    wcnt_nxt_s      = wcnt_r;
    frame_cnt_nxt_s = frame_cnt_r;
    frame_err_nxt_s = frame_err_r;

    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase

    if (pop_s && m_last_s) begin
      wcnt_nxt_s      = {CW{1'b0}};
      frame_cnt_nxt_s = frame_cnt_r + 16'd1;
    end else if (pop_s) begin
      wcnt_nxt_s      = wcnt_r + CW'(1);
      frame_cnt_nxt_s = frame_cnt_r;
    end else begin
      wcnt_nxt_s      = wcnt_r;
      frame_cnt_nxt_s = frame_cnt_r;
    end

    // A mismatch in the same cycle as err_clr keeps the flag set.
    if (mismatch_s) begin
      frame_err_nxt_s = 1'b1;
    end else if (err_clr) begin
      frame_err_nxt_s = 1'b0;
    end else begin
      frame_err_nxt_s = frame_err_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_r     <= {LW{1'b0}};
      wcnt_r      <= {CW{1'b0}};
      frame_cnt_r <= 16'd0;
      frame_err_r <= 1'b0;
    end else begin
      level_r     <= level_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_hyperspace_out_framer.sv
// tb_hyperspace_out_framer: directed table-driven and sequence checks for hyperspace_out_framer.
module tb_hyperspace_out_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic [2:0]  level;
  logic [15:0] frame_cnt;
  logic        frame_err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  hyperspace_out_framer #(.DATA_W(16), .DEPTH(4), .FRAME_LEN(1536)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .level(level), .frame_cnt(frame_cnt), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s_valid;
    logic [15:0] s_data;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    logic [15:0] exp_m_data;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] exp_data(input logic [15:0] w);
`ifdef HYPERSPACE_OUT_BITREV_EN
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0000;
    m_ready = 1'b0; err_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Streams n words base..base+n-1 with m_ready=1; tallies m_last positions and data errors.
  task automatic run_stream(input int n, input int last_at, input logic [15:0] base,
                            output int nlast, output int first_last, output int derr);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    nlast = 0; first_last = -1; derr = 0;
    m_ready = 1'b1;
    while (got < n && cyc < n + 50) begin
      s_valid = (sent < n);
      s_data  = 16'(base + sent);
      s_last  = (sent == last_at);
      @(negedge clock);
      if (m_valid) begin
        if (m_data !== exp_data(16'(base + got))) derr++;
        if (m_last) begin
          nlast++;
          if (first_last < 0) first_last = got;
        end
        got++;
      end
      if (s_valid && s_ready) sent++;
      step();
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    check("stream_complete", got, n);
  endtask

  initial begin
    int nl, fl, de;

    vecs[0]  = '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, exp_data(16'hA001), 3'd1};
    vecs[2]  = '{1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, exp_data(16'hA001), 3'd2};
    vecs[3]  = '{1'b1, 16'hA004, 1'b0, 1'b1, 1'b1, exp_data(16'hA001), 3'd3};
    vecs[4]  = '{1'b1, 16'hA005, 1'b0, 1'b0, 1'b1, exp_data(16'hA001), 3'd4};
    vecs[5]  = '{1'b1, 16'hA005, 1'b1, 1'b0, 1'b1, exp_data(16'hA001), 3'd4};
    vecs[6]  = '{1'b1, 16'hA005, 1'b1, 1'b1, 1'b1, exp_data(16'hA002), 3'd3};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, exp_data(16'hA003), 3'd3};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, exp_data(16'hA004), 3'd2};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, exp_data(16'hA005), 3'd1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};

    do_reset();
    @(negedge clock);
    check("rst_level", level, 3'd0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_frame_err", frame_err, 1'b0);
    step();

    // Backpressure and ordering table.
    for (int i = 0; i < 11; i++) begin
      s_valid = vecs[i].s_valid; s_data = vecs[i].s_data; s_last = 1'b0;
      m_ready = vecs[i].m_ready;
      @(negedge clock);
      check($sformatf("bp%0d_s_ready", i), s_ready, vecs[i].exp_s_ready);
      check($sformatf("bp%0d_m_valid", i), m_valid, vecs[i].exp_m_valid);
      check($sformatf("bp%0d_level", i), level, vecs[i].exp_level);
      check($sformatf("bp%0d_m_last", i), m_last, 1'b0);
      if (vecs[i].exp_m_valid) check($sformatf("bp%0d_m_data", i), m_data, vecs[i].exp_m_data);
      step();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    check("bp_frame_err", frame_err, 1'b0);

    // Nominal frame 0..1535.
    do_reset();
    run_stream(1536, 1535, 16'h0000, nl, fl, de);
    check("nom_nlast", nl, 1);
    check("nom_last_pos", fl, 1535);
    check("nom_data_err", de, 0);
    check("nom_frame_cnt", frame_cnt, 16'd1);
    check("nom_frame_err", frame_err, 1'b0);
    check("nom_level", level, 3'd0);

    // Early s_last, then a correct frame.
    do_reset();
    run_stream(100, 99, 16'h1000, nl, fl, de);
    check("early_nlast", nl, 1);
    check("early_last_pos", fl, 99);
    check("early_frame_err", frame_err, 1'b1);
    check("early_frame_cnt", frame_cnt, 16'd1);
    run_stream(1536, 1535, 16'h2000, nl, fl, de);
    check("after_early_nlast", nl, 1);
    check("after_early_last_pos", fl, 1535);
    check("after_early_data_err", de, 0);
    check("after_early_frame_cnt", frame_cnt, 16'd2);

    // Missing s_last, err_clr, and err_clr losing to a coincident mismatch.
    do_reset();
    run_stream(1536, -1, 16'h3000, nl, fl, de);
    check("miss_nlast", nl, 1);
    check("miss_last_pos", fl, 1535);
    check("miss_frame_err", frame_err, 1'b1);
    check("miss_frame_cnt", frame_cnt, 16'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clock);
    check("clr_frame_err", frame_err, 1'b0);
    step();
    s_valid = 1'b1; s_last = 1'b1; s_data = 16'h3ABC;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; err_clr = 1'b1;
    @(negedge clock);
    check("coinc_m_last", m_last, 1'b1);
    step();
    m_ready = 1'b0; err_clr = 1'b0;
    @(negedge clock);
    check("coinc_frame_err", frame_err, 1'b1);
    check("coinc_frame_cnt", frame_cnt, 16'd2);
    step();

    // Reset mid-frame with words buffered.
    do_reset();
    run_stream(700, -1, 16'h4000, nl, fl, de);
    check("mid_nlast", nl, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'(16'h5000 + i);
      step();
    end
    s_valid = 1'b0;
    @(negedge clock);
    check("mid_level", level, 3'd3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_frame_cnt", frame_cnt, 16'd0);
    step();
    run_stream(1536, 1535, 16'h6000, nl, fl, de);
    check("post_rst_nlast", nl, 1);
    check("post_rst_last_pos", fl, 1535);
    check("post_rst_data_err", de, 0);
    check("post_rst_frame_err", frame_err, 1'b0);
    check("post_rst_frame_cnt", frame_cnt, 16'd1);

    // Output bit order.
    do_reset();
    s_valid = 1'b1; s_data = 16'h0001;
    step();
    s_valid = 1'b0;
    @(negedge clock);
`ifdef HYPERSPACE_OUT_BITREV_EN
    check("order_0001", m_data, 16'h8000);
`else
    check("order_0001", m_data, 16'h0001);
`endif
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'hF00F;
    step();
    s_valid = 1'b0;
    @(negedge clock);
    check("order_F00F", m_data, 16'hF00F);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
